multi_div_sched: RTL
====================

Name: multi_div_sched

Overview:
Round-robin scheduler that shares one multi_div engine (iterative multiply/divide) among NUM_REQ requesters. It accepts one request at a time and issues a single-cycle start to the engine. It waits for the engine's Valid pulse, then returns the result to the requester that owns the operation. A watchdog flags an engine that never completes. It sits between the datapath clients and the multi_div instance, which it fully owns.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SIZE_A, 128, operand a width; must match the multi_div instance
SIZE_B, 64, operand b width; must match the multi_div instance
FAST_MODE, 2, engine iterations per cycle; must match the multi_div instance
WD_SLACK, 4, cycles allowed beyond the nominal engine latency before timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester request, held until gnt
req_select  in  NUM_REQ  per-requester op: 0 multiply, 1 divide
req_a  in  NUM_REQ*SIZE_A  packed operand a; slice i belongs to requester i
req_b  in  NUM_REQ*SIZE_B  packed operand b
gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse
done  out  NUM_REQ  one-hot, one-cycle completion pulse
result  out  SIZE_A+SIZE_B  result of the last completed op; held until the next done
err  out  1  sticky watchdog flag; cleared only by reset
busy  out  1  high from grant until done
md_en, md_select  out  1  engine start and op select
md_a  out  SIZE_A  engine operand a
md_b  out  SIZE_B  engine operand b
md_P  in  SIZE_A+SIZE_B  engine result
md_valid  in  1  engine Valid

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high. The engine's reset_n is driven as ~reset at integration, so both blocks reset together.
- Reset: all outputs are 0, state is IDLE, the round-robin pointer is 0 and err is 0.
- States: IDLE, WAIT.
- LAT = SIZE_A/FAST_MODE.
- IDLE, any req high:
  - Winner: the first requester at or after the pointer, scanning upward with wrap.
  - Next edge: gnt[winner]=1 and md_en=1 for exactly one cycle.
  - md_select/md_a/md_b are registered from the winner's slice and held stable until done.
  - owner <= winner; pointer <= winner+1 mod NUM_REQ; state -> WAIT.
- IDLE, no req: all outputs idle and nothing is issued.
- WAIT: a watchdog counter increments each cycle.
  - md_valid=1: result <= md_P; done[owner]=1 on the next cycle; state -> IDLE.
  - Watchdog reaches LAT+1+WD_SLACK first: err <= 1; result <= 0; done[owner]=1; state -> IDLE.
- Latency: with md_en in cycle 0, md_valid arrives in cycle LAT+1 and done in cycle LAT+2.
- A new grant comes no earlier than the cycle after done, so there is one op in flight at most.
- Requester rules:
  - Must deassert req in the cycle it sees gnt.
  - A req dropped before grant is legal and is simply not granted.
  - A req still high in the done cycle is eligible for the following arbitration, but at lowest priority.
- md_valid outside WAIT is ignored. An engine response that arrives after a timeout is discarded.
- Operand width rule: md_P is copied to result unmodified.
  - Multiply: product.
  - Divide: quotient, zero-extended; the remainder is not exposed.
- Reset mid-operation: the op is abandoned, with no done and no gnt.

Decomposition:
- Package multi_div_pkg:
  - state encoding (IDLE, WAIT)
  - OP_MUL=0, OP_DIV=1
  - function md_latency(SIZE_A, FAST_MODE)
  - watchdog width localparam
- Sub-module rr_pick: combinational one-hot round-robin selector (req vector, pointer -> one-hot winner, any). Instantiated once.

Test Plan:
(all scenarios use SIZE_A=8, SIZE_B=4, FAST_MODE=2, NUM_REQ=4, with a real multi_div instance)
- Single multiply: req[1], a=13, b=11 -> gnt[1] pulse, md_en for 1 cycle, done[1] 6 cycles after gnt, result=143.
- Single divide: req[2], select=1, a=100, b=7 -> done[2], result=14, err=0.
- Contention: req[3:0] all high at once, each dropping after its gnt -> grants in order 0,1,2,3, never two ops in flight, each done matches its owner.
- Fairness: req[0] re-asserted immediately after its done while req[2] waits -> req[2] granted before req[0] again.
- Timeout: engine stub never asserts md_valid -> err=1 at watchdog cycle LAT+1+WD_SLACK, done[owner] pulse, result=0; a late md_valid is ignored.
- Reset in WAIT: reset asserted mid-calculation -> gnt/done/busy/err=0 immediately; the next request is granted to requester 0 first.

Source files
------------

// File: rtl/multi_div_pkg.sv
// Shared types and constants for the round-robin scheduler in front of the
// iterative multi_div engine.
package multi_div_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } sched_state_e;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   // Covers watchdog limits up to 4095 cycles (SIZE_A=128 at one iteration per cycle plus slack).
   localparam int WD_W = 12;

   function automatic int md_latency(input int size_a, input int fast_mode);
      return size_a / fast_mode;
   endfunction

endpackage

// File: rtl/multi_div_sched_rr_pick.sv
// Combinational round-robin selector: the first requester at or after ptr,
// scanning upward with wrap, as a one-hot vector plus its index.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [PTR_W-1:0]   winner_idx,
   output logic               any
);

   logic [NUM_REQ-1:0] at_or_after;
   logic [NUM_REQ-1:0] hi_req;
   logic [NUM_REQ-1:0] pick;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
         assign at_or_after[gi] = (PTR_W'(gi) >= ptr);
      end
   endgenerate

   // Requests at/above the pointer take precedence; otherwise wrap to the bottom.
   assign hi_req = req & at_or_after;
   assign pick   = (|hi_req) ? hi_req : req;
   assign winner = pick & (~pick + NUM_REQ'(1));
   assign any    = |req;

   always_comb begin
      winner_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) winner_idx = winner_idx | PTR_W'(i);
      end
   end

endmodule

// File: rtl/multi_div_sched.sv
// Round-robin scheduler sharing one multi_div engine among NUM_REQ requesters,
// one operation in flight, with a sticky watchdog on engine completion.
module multi_div_sched
   import multi_div_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int SIZE_A    = 128,
   parameter int SIZE_B    = 64,
   parameter int FAST_MODE = 2,
   parameter int WD_SLACK  = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          req_select,
   input  logic [NUM_REQ*SIZE_A-1:0]   req_a,
   input  logic [NUM_REQ*SIZE_B-1:0]   req_b,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          done,
   output logic [SIZE_A+SIZE_B-1:0]    result,
   output logic                        err,
   output logic                        busy,
   output logic                        md_en,
   output logic                        md_select,
   output logic [SIZE_A-1:0]           md_a,
   output logic [SIZE_B-1:0]           md_b,
   input  logic [SIZE_A+SIZE_B-1:0]    md_P,
   input  logic                        md_valid
);

   localparam int PTR_W    = $clog2(NUM_REQ);
   localparam int LAT      = md_latency(SIZE_A, FAST_MODE);
   // md_valid is still accepted in the cycle the watchdog equals this value,
   // so a timeout's done lands WD_SLACK cycles after the nominal done.
   localparam int WD_LIMIT = LAT + 1 + WD_SLACK;
   localparam logic [WD_W-1:0] WD_LIMIT_V = WD_W'(WD_LIMIT);

   sched_state_e             state_reg, state_next;
   logic [PTR_W-1:0]         ptr_reg, ptr_next;
   logic [PTR_W-1:0]         owner_reg, owner_next;
   logic [WD_W-1:0]          wd_reg, wd_next;
   logic [NUM_REQ-1:0]       gnt_reg, gnt_next;
   logic [NUM_REQ-1:0]       done_reg, done_next;
   logic [SIZE_A+SIZE_B-1:0] result_reg, result_next;
   logic                     err_reg, err_next;
   logic                     md_en_reg, md_en_next;
   logic                     md_select_reg, md_select_next;
   logic [SIZE_A-1:0]        md_a_reg, md_a_next;
   logic [SIZE_B-1:0]        md_b_reg, md_b_next;

   logic [NUM_REQ-1:0]       pick_onehot;
   logic [PTR_W-1:0]         pick_idx;
   logic                     pick_any;

   logic [SIZE_A-1:0]        a_slice [NUM_REQ];
   logic [SIZE_B-1:0]        b_slice [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign a_slice[gi] = req_a[gi*SIZE_A +: SIZE_A];
         assign b_slice[gi] = req_b[gi*SIZE_B +: SIZE_B];
      end
   endgenerate

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .req        (req),
      .ptr        (ptr_reg),
      .winner     (pick_onehot),
      .winner_idx (pick_idx),
      .any        (pick_any)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         owner_reg     <= '0;
         wd_reg        <= '0;
         gnt_reg       <= '0;
         done_reg      <= '0;
         result_reg    <= '0;
         err_reg       <= 1'b0;
         md_en_reg     <= 1'b0;
         md_select_reg <= 1'b0;
         md_a_reg      <= '0;
         md_b_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         ptr_reg       <= ptr_next;
         owner_reg     <= owner_next;
         wd_reg        <= wd_next;
         gnt_reg       <= gnt_next;
         done_reg      <= done_next;
         result_reg    <= result_next;
         err_reg       <= err_next;
         md_en_reg     <= md_en_next;
         md_select_reg <= md_select_next;
         md_a_reg      <= md_a_next;
         md_b_reg      <= md_b_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      ptr_next       = ptr_reg;
      owner_next     = owner_reg;
      wd_next        = wd_reg;
      gnt_next       = '0;
      done_next      = '0;
      result_next    = result_reg;
      err_next       = err_reg;
      md_en_next     = 1'b0;
      md_select_next = md_select_reg;
      md_a_next      = md_a_reg;
      md_b_next      = md_b_reg;

      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               gnt_next       = pick_onehot;
               md_en_next     = 1'b1;
               md_select_next = req_select[pick_idx];
               md_a_next      = a_slice[pick_idx];
               md_b_next      = b_slice[pick_idx];
               owner_next     = pick_idx;
               ptr_next       = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
               wd_next        = '0;
               state_next     = WAIT;
            end
         end
         WAIT: begin
            wd_next = wd_reg + WD_W'(1);
            if (md_valid) begin
               result_next = md_P;
               done_next   = NUM_REQ'(1) << owner_reg;
               state_next  = IDLE;
            end else if (wd_reg == WD_LIMIT_V) begin
               err_next    = 1'b1;
               result_next = '0;
               done_next   = NUM_REQ'(1) << owner_reg;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign gnt       = gnt_reg;
   assign done      = done_reg;
   assign result    = result_reg;
   assign err       = err_reg;
   assign busy      = (state_reg == WAIT);
   assign md_en     = md_en_reg;
   assign md_select = md_select_reg;
   assign md_a      = md_a_reg;
   assign md_b      = md_b_reg;

endmodule
